// File: rtl/microwave_if.sv
// Microwave controller signal bundle.
// Groups the operator inputs, the down-counter handshake and the appliance
// outputs of microwave_ctrl into one interface.
//   master : the environment side (panel, door sensor, down counter)
//   slave  : the controller side (microwave_ctrl)
// Signals:
//   start_btn, stop_btn : level buttons, active-high
//   door_open           : 1 = door open
//   timerEnd            : heating complete, from the down counter
//   minutes, seconds    : current counter value (zero test only)
//   start, rst_cnt      : count enable / load request to the down counter
//   magnetron_on, lamp_on, beep : appliance outputs
//   state               : current FSM state code (debug / LEDs)
interface microwave_if;
  logic       start_btn;
  logic       stop_btn;
  logic       door_open;
  logic       timerEnd;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       start;
  logic       rst_cnt;
  logic       magnetron_on;
  logic       lamp_on;
  logic       beep;
  logic [1:0] state;

  modport master (
    output start_btn, stop_btn, door_open, timerEnd, minutes, seconds,
    input  start, rst_cnt, magnetron_on, lamp_on, beep, state
  );

  modport slave (
    input  start_btn, stop_btn, door_open, timerEnd, minutes, seconds,
    output start, rst_cnt, magnetron_on, lamp_on, beep, state
  );
endinterface

// File: rtl/microwave_ctrl.sv
// Microwave oven controller: Moore FSM IDLE -> COOK -> DONE with a PAUSE
// state entered on door open or stop. Buttons are rising-edge detected so a
// held button yields one press. PAUSE times out back to IDLE 60 edges after
// entry; DONE beeps for 3 edges.
// Ports:
//   clk_1Hz : 1 Hz clock, all state changes on its rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : microwave_if.slave (inputs, counter handshake, outputs, state)
// Inputs are sampled on the edge; there is no valid/ready handshake, every
// edge is a transaction and every output is valid whenever rst_n is stable.
module microwave_ctrl (
  input  logic        clk_1Hz,
  input  logic        rst_n,
  microwave_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       start_prev;
  logic       stop_prev;
  logic [5:0] pause_cnt;
  logic [1:0] beep_cnt;

  logic start_press;
  logic stop_press;
  logic time_nonzero;

  assign start_press  = bus.start_btn & ~start_prev;
  assign stop_press   = bus.stop_btn & ~stop_prev;
  assign time_nonzero = ({bus.minutes, bus.seconds} != 12'd0);

  // State register, button history and dwell counters.
  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      start_prev <= 1'b0;
      stop_prev  <= 1'b0;
      pause_cnt  <= 6'd0;
      beep_cnt   <= 2'd0;
    end else begin
      state_q    <= state_d;
      start_prev <= bus.start_btn;
      stop_prev  <= bus.stop_btn;
      // Counters read 0 on the edge that enters their state because they are
      // held clear while outside it; inside they count edges spent there.
      if (state_q == PAUSE) begin
        if (pause_cnt != 6'd59)
          pause_cnt <= pause_cnt + 6'd1;
      end else begin
        pause_cnt <= 6'd0;
      end
      if (state_q == DONE)
        beep_cnt <= beep_cnt + 2'd1;
      else
        beep_cnt <= 2'd0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // Stop wins over a simultaneous start: no transition.
        if (start_press && !stop_press && !bus.door_open && time_nonzero)
          state_d = COOK;
      end
      COOK: begin
        if (bus.timerEnd)
          state_d = DONE;
        else if (bus.door_open || stop_press)
          state_d = PAUSE;
      end
      PAUSE: begin
        if (stop_press || (pause_cnt == 6'd59))
          state_d = IDLE;
        else if (start_press && !bus.door_open)
          state_d = COOK;
      end
      DONE: begin
        if ((beep_cnt == 2'd2) || stop_press || bus.door_open)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode from the state register only, so reset forces the
  // IDLE outputs immediately without waiting for a clock edge.
  always_comb begin
    bus.start        = 1'b0;
    bus.rst_cnt      = 1'b0;
    bus.magnetron_on = 1'b0;
    bus.lamp_on      = 1'b0;
    bus.beep         = 1'b0;
    case (state_q)
      IDLE:  bus.rst_cnt = 1'b1;
      COOK: begin
        bus.start        = 1'b1;
        bus.magnetron_on = 1'b1;
        bus.lamp_on      = 1'b1;
      end
      PAUSE: bus.lamp_on = 1'b1;
      DONE:  bus.beep    = 1'b1;
      default: bus.rst_cnt = 1'b1;
    endcase
  end

  assign bus.state = state_q;

endmodule
